// File: rtl/timer_ctrl.sv
// timer_ctrl: run/pause/finish control for the BCD down-counter timer.
// Conditions the raw buttons, divides clk into count ticks, and drives the
// counter's 2-bit state code (IDLE load / STOP hold / COUNTING decrement).
module timer_ctrl #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       done,
    output logic [1:0] state,
    output logic       running,
    output logic       finished,
    output logic       blink
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STOP  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_FINISH
    } fsm_t;

    fsm_t             fsm;
    logic [DIV_W-1:0] presc;
    logic [2:0]       start_sr;  // [0]=sync1, [1]=sync2, [2]=edge-detect delay
    logic [2:0]       clear_sr;
    logic             start_pulse;
    logic             clear_pulse;
    logic             presc_wrap;
    logic [DIV_W-1:0] presc_nxt;
    logic             tick;

    // Two-flop synchronisers plus one delay stage for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sr <= '0;
            clear_sr <= '0;
        end else begin
            start_sr <= {start_sr[1:0], btn_start};
            clear_sr <= {clear_sr[1:0], btn_clear};
        end
    end

    assign start_pulse = start_sr[1] & ~start_sr[2];
    assign clear_pulse = clear_sr[1] & ~clear_sr[2];

    assign presc_wrap = (presc == DIV_MAX);
    assign presc_nxt  = presc_wrap ? '0 : presc + 1'b1;
    assign tick       = (fsm == S_RUN) && presc_wrap;

    // Control FSM with prescaler and blink; clear beats done-on-tick beats start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= S_IDLE;
            presc <= '0;
            blink <= 1'b0;
        end else if (clear_pulse) begin
            fsm   <= S_IDLE;
            presc <= '0;
            blink <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    presc <= '0;
                    blink <= 1'b0;
                    if (start_pulse) fsm <= S_RUN;
                end
                S_RUN: begin
                    if (tick && done) begin
                        // Counter hit 00: finish, start on the same edge is dropped
                        fsm   <= S_FINISH;
                        presc <= '0;
                        blink <= 1'b0;
                    end else begin
                        presc <= presc_nxt;
                        if (start_pulse) fsm <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    // Prescaler holds so the resumed tick phase is preserved
                    if (start_pulse) fsm <= S_RUN;
                end
                S_FINISH: begin
                    if (start_pulse) begin
                        fsm   <= S_IDLE;
                        presc <= '0;
                        blink <= 1'b0;
                    end else begin
                        presc <= presc_nxt;
                        if (presc_wrap) blink <= ~blink;
                    end
                end
                default: begin
                    fsm   <= S_IDLE;
                    presc <= '0;
                    blink <= 1'b0;
                end
            endcase
        end
    end

    // Counter state code: COUNTING only on the tick cycle of RUN
    always_comb begin
        state = ST_STOP;
        case (fsm)
            S_IDLE:  state = ST_IDLE;
            S_RUN:   state = tick ? ST_COUNT : ST_STOP;
            default: state = ST_STOP;
        endcase
    end

    assign running  = (fsm == S_RUN);
    assign finished = (fsm == S_FINISH);

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl: behavioural model + BCD counter stub, directed
// scenarios with literal expectations, then randomized button activity.
module tb_timer_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic       done;
    logic [1:0] state;
    logic       running;
    logic       finished;
    logic       blink;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.TICK_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .done      (done),
        .state     (state),
        .running   (running),
        .finished  (finished),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counter stub ----------------
    int         stub_init = 9;
    int         stub_cnt  = 0;
    logic [1:0] st_q      = 2'd0;

    assign done = (state == 2'd2) && (stub_cnt == 0);

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 run, 2 pause, 3 finish; phase = cycles into current tick period
    int   m_mode  = 0;
    int   m_phase = 0;
    bit   m_blink = 1'b0;
    bit   hs[3];
    bit   hc[3];
    bit   n_start, n_clr, n_done;

    // Mid-cycle sampling of everything the model and stub consume
    initial forever begin
        @(negedge clk);
        n_start = btn_start;
        n_clr   = btn_clear;
        n_done  = done;
        st_q    = state;
    end

    // Stub: load on IDLE, decrement on COUNTING, stop at 00
    initial forever begin
        @(posedge clk);
        if (st_q == 2'd0)                       stub_cnt <= stub_init;
        else if (st_q == 2'd2 && stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    end

    initial forever begin
        bit sp, cp, tk;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_phase = 0; m_blink = 0;
            for (int i = 0; i < 3; i++) begin hs[i] = 0; hc[i] = 0; end
        end else begin
            // A press is seen when sampled high two edges ago and low three ago
            sp = hs[1] && !hs[2];
            cp = hc[1] && !hc[2];
            hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = n_start;
            hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = n_clr;
            tk = (m_mode == 1) && (m_phase == D - 1);
            if (cp) begin
                m_mode = 0; m_phase = 0; m_blink = 0;
            end else if (m_mode == 0) begin
                m_phase = 0; m_blink = 0;
                if (sp) m_mode = 1;
            end else if (m_mode == 1) begin
                if (tk && n_done) begin
                    m_mode = 3; m_phase = 0; m_blink = 0;
                end else begin
                    m_phase = (m_phase + 1) % D;
                    if (sp) m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (sp) m_mode = 1;
            end else begin
                if (sp) begin
                    m_mode = 0; m_phase = 0; m_blink = 0;
                end else begin
                    if (m_phase == D - 1) m_blink = !m_blink;
                    m_phase = (m_phase + 1) % D;
                end
            end
        end
    end

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 1 && m_phase == D - 1) return 2;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #1;
        chk("model_state",    32'(state),    32'(exp_state()));
        chk("model_running",  32'(running),  32'(m_mode == 1));
        chk("model_finished", 32'(finished), 32'(m_mode == 3));
        chk("model_blink",    32'(blink),    32'(m_blink));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Poll with a cycle budget; expiry is a failed comparison
    task automatic wait_for(input string nm, input int which, input int maxc);
        int n = 0;
        while (!((which == 0) ? (state == 2'd2) : (finished == 1'b1)) && n < maxc) begin
            step(1);
            n++;
        end
        chk(nm, 32'((which == 0) ? (state == 2'd2) : (finished == 1'b1)), 32'd1);
    endtask

    initial begin
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
        step(3);
        rst = 1'b0;

        // Idle with no buttons
        step(6);
        chk("idle_state",    32'(state),    32'd0);
        chk("idle_running",  32'(running),  32'd0);
        chk("idle_finished", 32'(finished), 32'd0);
        chk("idle_blink",    32'(blink),    32'd0);

        // Start held 10 cycles: acts on the 3rd edge, COUNTING after 4 RUN cycles
        stub_init = 9;
        btn_start = 1'b1;
        step(2);
        chk("start_lat_edge2", 32'(running), 32'd0);
        step(1);
        chk("start_lat_edge3", 32'(running), 32'd1);
        step(2);
        chk("first_tick_pre", 32'(state), 32'd1);
        step(1);
        chk("first_tick", 32'(state), 32'd2);
        step(1);
        chk("after_tick", 32'(state), 32'd1);
        step(3);
        btn_start = 1'b0;
        step(4);
        chk("held_one_pulse", 32'(running), 32'd1);

        // Pause two cycles after a COUNTING cycle, then resume
        wait_for("wait_count", 0, 20);
        btn_start = 1'b1;
        step(3);
        chk("pause_running", 32'(running), 32'd0);
        chk("pause_state",   32'(state),   32'd1);
        btn_start = 1'b0;
        step(6);
        chk("pause_hold", 32'(state), 32'd1);
        btn_start = 1'b1;
        step(3);
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_state",   32'(state),   32'd1);
        step(1);
        chk("resume_tick", 32'(state), 32'd2);
        btn_start = 1'b0;

        // Run to completion, blink every 4 cycles, acknowledge
        wait_for("wait_finish", 1, 200);
        chk("fin_state", 32'(state), 32'd1);
        chk("fin_blink0", 32'(blink), 32'd0);
        step(4);
        chk("fin_blink1", 32'(blink), 32'd1);
        step(4);
        chk("fin_blink2", 32'(blink), 32'd0);
        btn_start = 1'b1;
        step(3);
        chk("ack_state",    32'(state),    32'd0);
        chk("ack_finished", 32'(finished), 32'd0);
        chk("ack_blink",    32'(blink),    32'd0);
        btn_start = 1'b0;
        step(3);

        // Clear and start in the same cycle while running: clear wins
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(6);
        btn_start = 1'b1; btn_clear = 1'b1;
        step(3);
        chk("clear_wins_state",   32'(state),   32'd0);
        chk("clear_wins_running", 32'(running), 32'd0);
        btn_start = 1'b0; btn_clear = 1'b0;
        step(3);

        // Start pulse lands on the done tick: FINISH, not PAUSE
        stub_init = 0;
        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
        step(3);
        btn_start = 1'b1;
        step(3);
        chk("done_beats_start_fin", 32'(finished), 32'd1);
        chk("done_beats_start_run", 32'(running),  32'd0);
        btn_start = 1'b0;
        step(1);
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(3);

        // Asynchronous reset mid-run, between ticks
        stub_init = 9;
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_state",    32'(state),    32'd0);
        chk("arst_running",  32'(running),  32'd0);
        chk("arst_finished", 32'(finished), 32'd0);
        chk("arst_blink",    32'(blink),    32'd0);
        step(2);
        rst = 1'b0;
        step(2);
        btn_start = 1'b1;
        step(2);
        chk("post_rst_edge2", 32'(running), 32'd0);
        step(1);
        chk("post_rst_edge3", 32'(running), 32'd1);
        btn_start = 1'b0;
        step(2);

        // Randomized button activity against the model
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 9);
            stub_init = $urandom_range(0, 5);
            if (r < 6) begin
                btn_start = 1'b1;
                step($urandom_range(1, 6));
                btn_start = 1'b0;
                step($urandom_range(1, 12));
            end else if (r < 8) begin
                step($urandom_range(1, 20));
            end else if (r == 8) begin
                btn_clear = 1'b1;
                step($urandom_range(1, 3));
                btn_clear = 1'b0;
                step($urandom_range(1, 8));
            end else begin
                btn_start = 1'b1; btn_clear = 1'b1;
                step(2);
                btn_start = 1'b0; btn_clear = 1'b0;
                step($urandom_range(1, 8));
            end
        end
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
